// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe game controller: conditions the switches and buttons, places marks
// for alternating players and reports win/tie to the board display driver.
module ttt_move_ctrl #(
  parameter int DB_COUNT = 500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW,
  input  logic       BTN_PLACE,
  input  logic       BTN_NEW,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] win,
  output logic       player,
  output logic       MOVE_ERR
);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  localparam int CW = $clog2(DB_COUNT) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_COUNT - 1);

  state_t            state_q, state_d;
  logic [3:0]        sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [1:0]        btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [1:0]        lvl_q, lvl_d, lvl_prev_q, lvl_prev_d, pulse_q, pulse_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [8:0][1:0]   board_q, board_d;
  logic [1:0]        win_q, win_d;
  logic              player_q, player_d;
  logic              move_err_q, move_err_d;

  logic              place_p, new_p;
  logic [3:0]        idx;
  logic              sw_ok;
  logic [1:0]        line_val;
  logic              full;

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c);
    return (a != 2'd0 && a == b && a == c) ? a : 2'd0;
  endfunction

  // Index 0 is the place button, index 1 the new-game button.
  always_comb begin
    sw_s1_d    = SW;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = {BTN_NEW, BTN_PLACE};
    btn_s2_d   = btn_s1_q;
    lvl_d      = lvl_q;
    cnt_d      = '0;
    lvl_prev_d = lvl_q;
    pulse_d    = lvl_q & ~lvl_prev_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) lvl_d[i] = btn_s2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign place_p = pulse_q[0];
  assign new_p   = pulse_q[1];
  assign idx     = sw_s2_q - 4'd1;
  assign sw_ok   = (sw_s2_q != 4'd0) && (sw_s2_q <= 4'd9);

  always_comb begin
    line_val = line3(board_q[0], board_q[1], board_q[2]) |
               line3(board_q[3], board_q[4], board_q[5]) |
               line3(board_q[6], board_q[7], board_q[8]) |
               line3(board_q[0], board_q[3], board_q[6]) |
               line3(board_q[1], board_q[4], board_q[7]) |
               line3(board_q[2], board_q[5], board_q[8]) |
               line3(board_q[0], board_q[4], board_q[8]) |
               line3(board_q[2], board_q[4], board_q[6]);
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board_q[i] == 2'd0) full = 1'b0;
    end
  end

  // Only the mover can complete lines, so OR-ing the per-line results is safe.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    win_d      = win_q;
    player_d   = player_q;
    move_err_d = 1'b0;
    if (new_p) begin
      board_d  = '0;
      win_d    = 2'd0;
      player_d = 1'b0;
      state_d  = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (place_p) begin
            if (sw_ok && board_q[idx] == 2'd0) begin
              board_d[idx] = {1'b0, player_q} + 2'd1;
              state_d      = CHECK;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_val != 2'd0) begin
            win_d   = line_val;
            state_d = OVER;
          end else if (full) begin
            win_d   = 2'd3;
            state_d = OVER;
          end else begin
            player_d = ~player_q;
            state_d  = PLAY;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= PLAY;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      pulse_q    <= '0;
      cnt_q      <= '0;
      board_q    <= '0;
      win_q      <= '0;
      player_q   <= 1'b0;
      move_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_prev_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      board_q    <= board_d;
      win_q      <= win_d;
      player_q   <= player_d;
      move_err_q <= move_err_d;
    end
  end

  assign pos1     = board_q[0];
  assign pos2     = board_q[1];
  assign pos3     = board_q[2];
  assign pos4     = board_q[3];
  assign pos5     = board_q[4];
  assign pos6     = board_q[5];
  assign pos7     = board_q[6];
  assign pos8     = board_q[7];
  assign pos9     = board_q[8];
  assign win      = win_q;
  assign player   = player_q;
  assign MOVE_ERR = move_err_q;

endmodule

// File: doc/ttt_move_ctrl.md
# ttt_move_ctrl

Game-state controller for the tic-tac-toe design, and the producer for the seven-segment board display driver. It takes the board switches and two push buttons, debounces them, and places marks for alternating players. It detects wins and ties and drives the 2-bit board cells `pos1`..`pos9`, `win` and `player` that the display block consumes. It is a direct source for that block, with no glue between them.

## Interface
Parameters:
- `DB_COUNT`, default 500000: number of consecutive stable synchronized samples needed to accept a button level change (5 ms at 100 MHz).

Ports:
- `CLK`, in, 1: system clock; the only clock in the block.
- `RST_N`, in, 1: reset, synchronous, active-low.
- `SW`, in, 4: cell index selected on the switches; 1..9 is valid.
- `BTN_PLACE`, in, 1: raw place button, asynchronous and bouncy.
- `BTN_NEW`, in, 1: raw new-game button, asynchronous and bouncy.
- `pos1`..`pos9`, out, 2 each: cell state. 0 = empty, 1 = player-1 mark, 2 = player-2 mark, 3 = never driven.
- `win`, out, 2: game result. 0 = in progress, 1 = player 1 won, 2 = player 2 won, 3 = tie.
- `player`, out, 1: player to move. 0 = player 1, 1 = player 2.
- `MOVE_ERR`, out, 1: one-cycle pulse when a place request is rejected.

## Operation
Input conditioning:
- `SW`, `BTN_PLACE` and `BTN_NEW` each pass through a 2-flop synchronizer.
- Each button has its own debouncer: a debounced level register plus a counter.
  - The counter resets to 0 whenever the synchronized input equals the debounced level.
  - Otherwise the counter increments. When it reaches `DB_COUNT - 1`, the debounced level flips and the counter clears.
- A rising edge of the debounced level produces a one-cycle pulse, `place_p` or `new_p`. Falling edges produce nothing.

State machine, with states PLAY, CHECK and OVER:
- PLAY, on `place_p`:
  - Accept when synchronized `SW` is in 1..9 and that cell is 0. The cell is written with `player + 1` and the next state is CHECK.
  - Reject when `SW` is 0 or 10..15, or the cell is non-zero. `MOVE_ERR` pulses for 1 cycle, the board is unchanged and the state stays PLAY.
- CHECK, always exactly 1 cycle. Evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board.
  - Any line with all three cells equal and non-zero: `win` takes that cell value and the next state is OVER.
  - Else, all 9 cells non-zero: `win` = 3 and the next state is OVER.
  - Else: toggle `player` and return to PLAY.
  - A win completed on the 9th move reports the winner, never a tie.
- OVER: `place_p` is ignored, with no `MOVE_ERR`. `player` holds the last mover.
- `new_p` in any state has priority over `place_p`. It clears all cells, sets `win` = 0 and `player` = 0, and moves to PLAY.
- Only the mover can complete a line, so two lines completing together always share one value; no arbitration is needed.

## Timing
- Reset values, applied on a `CLK` edge with `RST_N` = 0:
  - all `pos` = 0, `win` = 0, `player` = 0, `MOVE_ERR` = 0, state PLAY;
  - debounced levels 0, counters 0, synchronizer flops 0.
- Reset mid-game or mid-debounce discards everything; there is no partial state.
- Button latency: after a clean raw edge held stable, the pulse asserts exactly `DB_COUNT + 3` cycles later (2 sync + `DB_COUNT` count + 1 edge-detect). A glitch shorter than `DB_COUNT` cycles never produces a pulse.
- `SW` is sampled in the `place_p` cycle. `SW` must be stable for at least 2 cycles before that.
- Cell write and `MOVE_ERR` are visible the cycle after `place_p` (cycle P+1).
- `win` and `player` update at P+2, when CHECK completes.
- A new `place_p` can be accepted from P+2 onward. A `place_p` that arrives during CHECK is dropped; the debounce spacing makes this unreachable in practice.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Run every scenario with `DB_COUNT` = 4.
- Reset then idle: all `pos` = 0, `win` = 0, `player` = 0, `MOVE_ERR` = 0. Pulse `BTN_PLACE` for 2 cycles only: no pulse is generated and the board is unchanged.
- `SW` = 5, press `BTN_PLACE` cleanly: `pos5` = 1 exactly 8 cycles after the raw edge (7 cycles to `place_p`, written at P+1), then `player` = 1 at P+2. Next `SW` = 1 press gives `pos1` = 2 and `player` = 0.
- Illegal moves:
  - `SW` = 5 again gives one `MOVE_ERR` pulse and `player` stays unchanged.
  - `SW` = 0 and `SW` = 12 each give a `MOVE_ERR` pulse with no board change.
- Player 1 takes cells 1, 2, 3 while player 2 takes 4 and 5: `win` = 1 at P+2 of the move on cell 3, with `player` held at 0. Further presses change nothing and raise no `MOVE_ERR`.
- Tie, player 1 on 1,3,4,8,9 and player 2 on 2,5,6,7: after the 9th move `win` = 3. Separately, a 9th move that completes a diagonal gives `win` = 1, not 3.
- Mid-game behaviour:
  - Pressing `BTN_NEW` clears all cells and sets `win` = 0, `player` = 0.
  - Asserting `RST_N` = 0 for 1 cycle while a debounce count is in flight leaves no pulse afterwards.
